// File: rtl/pipeline_controller_if.sv
// Control bundle between the pipeline sequencer and the datapath.
// The controller sits on the master side; the datapath (or a bench) sits on the slave side.
interface pipeline_controller_if #(
    parameter int CNT_W = 32
);
    // Hazard and status inputs from the datapath stages
    logic             ihit;
    logic             dhit;
    logic             m_dREN;
    logic             m_dWEN;
    logic             m_halt;
    logic             m_redirect;
    logic             e_dREN;
    logic [4:0]       e_regWSEL;
    logic [4:0]       d_rs;
    logic [4:0]       d_rt;
    logic             d_uses_rt;

    // Sequencing outputs to the datapath
    logic             pc_en;
    logic             iREN;
    logic [1:0]       fd_state;
    logic [1:0]       de_state;
    logic [1:0]       em_state;
    logic [1:0]       mw_state;
    logic             halt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        input  ihit, dhit, m_dREN, m_dWEN, m_halt, m_redirect,
               e_dREN, e_regWSEL, d_rs, d_rt, d_uses_rt,
        output pc_en, iREN, fd_state, de_state, em_state, mw_state,
               halt, stall_cnt, flush_cnt
    );

    modport slave (
        output ihit, dhit, m_dREN, m_dWEN, m_halt, m_redirect,
               e_dREN, e_regWSEL, d_rs, d_rt, d_uses_rt,
        input  pc_en, iREN, fd_state, de_state, em_state, mw_state,
               halt, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_controller.sv
// Central sequencer for the 5-stage pipeline: drives the four pipeline latch
// controls and PC enable, resolves cache-miss stalls, load-use hazards and
// redirect flushes, runs the halt drain, and keeps two saturating counters.
module pipeline_controller #(
    parameter int DRAIN_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic CLK,
    input  logic nRST,
    pipeline_controller_if.master bus
);
    typedef enum logic [1:0] {
        NORMAL = 2'b00,
        STALL  = 2'b01,
        FLUSH  = 2'b10
    } pipe_state_t;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        DRAIN  = 2'b01,
        HALTED = 2'b10
    } ctrl_state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    ctrl_state_t      state_reg, state_next;
    logic             ifetch_done_reg, ifetch_done_next;
    logic [3:0]       drain_cnt_reg, drain_cnt_next;
    logic             halt_reg;
    logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;
    logic [CNT_W-1:0] flush_cnt_reg, flush_cnt_next;

    logic             dbusy;
    logic             fetched;
    logic             load_use;
    logic             pc_en_c;
    logic             flush_inc;
    pipe_state_t      fd_c, de_c, em_c, mw_c;

    assign dbusy    = (bus.m_dREN | bus.m_dWEN) & ~bus.dhit;
    assign fetched  = bus.ihit | ifetch_done_reg;
    assign load_use = bus.e_dREN & (bus.e_regWSEL != 5'd0) &
                      ((bus.e_regWSEL == bus.d_rs) |
                       (bus.d_uses_rt & (bus.e_regWSEL == bus.d_rt)));

    // Next-state and latch-control decode, highest-priority hazard first
    always_comb begin
        state_next       = state_reg;
        ifetch_done_next = ifetch_done_reg;
        drain_cnt_next   = drain_cnt_reg;
        pc_en_c          = 1'b0;
        flush_inc        = 1'b0;
        fd_c             = STALL;
        de_c             = STALL;
        em_c             = STALL;
        mw_c             = STALL;

        case (state_reg)
            RUN: begin
                if (dbusy) begin
                    // Everything freezes; remember a fetch that landed meanwhile
                    if (bus.ihit) begin
                        ifetch_done_next = 1'b1;
                    end
                end else if (bus.m_halt) begin
                    // Let the halt move to WB and stop fetching
                    em_c           = FLUSH;
                    mw_c           = NORMAL;
                    state_next     = DRAIN;
                    drain_cnt_next = DRAIN_LOAD;
                end else if (!fetched) begin
                    fd_c = FLUSH;
                    de_c = NORMAL;
                    em_c = NORMAL;
                    mw_c = NORMAL;
                end else if (bus.m_redirect) begin
                    pc_en_c   = 1'b1;
                    fd_c      = FLUSH;
                    de_c      = FLUSH;
                    em_c      = FLUSH;
                    mw_c      = NORMAL;
                    flush_inc = 1'b1;
                end else if (load_use) begin
                    de_c = FLUSH;
                    em_c = NORMAL;
                    mw_c = NORMAL;
                end else begin
                    pc_en_c = 1'b1;
                    fd_c    = NORMAL;
                    de_c    = NORMAL;
                    em_c    = NORMAL;
                    mw_c    = NORMAL;
                end
                // A consumed fetch (PC advanced or redirect flush) clears the flag
                if (pc_en_c) begin
                    ifetch_done_next = 1'b0;
                end
            end
            DRAIN: begin
                em_c = FLUSH;
                mw_c = NORMAL;
                if (drain_cnt_reg == 4'd0) begin
                    state_next = HALTED;
                end else begin
                    drain_cnt_next = drain_cnt_reg - 4'd1;
                end
            end
            default: begin
                state_next = HALTED;
            end
        endcase

        // Saturating performance counters
        stall_cnt_next = stall_cnt_reg;
        if ((state_reg == RUN) && !pc_en_c && (stall_cnt_reg != '1)) begin
            stall_cnt_next = stall_cnt_reg + CNT_W'(1);
        end
        flush_cnt_next = flush_cnt_reg;
        if (flush_inc && (flush_cnt_reg != '1)) begin
            flush_cnt_next = flush_cnt_reg + CNT_W'(1);
        end
    end

    // State, flag and counter registers with asynchronous reset
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg       <= RUN;
            ifetch_done_reg <= 1'b0;
            drain_cnt_reg   <= 4'd0;
            halt_reg        <= 1'b0;
            stall_cnt_reg   <= '0;
            flush_cnt_reg   <= '0;
        end else begin
            state_reg       <= state_next;
            ifetch_done_reg <= ifetch_done_next;
            drain_cnt_reg   <= drain_cnt_next;
            halt_reg        <= (state_next == HALTED);
            stall_cnt_reg   <= stall_cnt_next;
            flush_cnt_reg   <= flush_cnt_next;
        end
    end

    // While reset is held the pipeline is frozen regardless of inputs
    assign bus.pc_en     = nRST & pc_en_c;
    assign bus.fd_state  = nRST ? fd_c : STALL;
    assign bus.de_state  = nRST ? de_c : STALL;
    assign bus.em_state  = nRST ? em_c : STALL;
    assign bus.mw_state  = nRST ? mw_c : STALL;
    assign bus.iREN      = ~ifetch_done_reg & (state_reg == RUN);
    assign bus.halt      = halt_reg;
    assign bus.stall_cnt = stall_cnt_reg;
    assign bus.flush_cnt = flush_cnt_reg;
endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller: a table of per-cycle vectors on a
// default-parameter instance, plus hand sequences for async reset, counter
// saturation and a longer drain on a narrow-counter instance.
module tb_pipeline_controller;
    localparam logic [1:0] N = 2'b00;
    localparam logic [1:0] S = 2'b01;
    localparam logic [1:0] F = 2'b10;

    typedef struct {
        logic        ihit, dhit, drd, dwr, mh, mr, edr;
        logic [4:0]  ews, rs, rt;
        logic        urt;
        logic [10:0] exp_out;   // {pc_en, iREN, fd, de, em, mw, halt}
    } vec_t;

    logic clk;
    logic nrst;
    logic nrst2;
    int   n_cmp;
    int   n_bad;
    vec_t vecs[$];

    pipeline_controller_if #(.CNT_W(32)) if1 ();
    pipeline_controller_if #(.CNT_W(3))  if2 ();

    pipeline_controller #(.DRAIN_CYCLES(1), .CNT_W(32)) dut1 (
        .CLK (clk),
        .nRST(nrst),
        .bus (if1)
    );

    pipeline_controller #(.DRAIN_CYCLES(3), .CNT_W(3)) dut2 (
        .CLK (clk),
        .nRST(nrst2),
        .bus (if2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp_v);
        n_cmp++;
        if (got !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp_v);
        end else begin
            $display("ok   %s: %0h", nm, got);
        end
    endtask

    task automatic add(input logic ihit, input logic dhit, input logic drd, input logic dwr,
                       input logic mh, input logic mr, input logic edr,
                       input logic [4:0] ews, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urt, input logic [10:0] exp_out);
        vec_t v;
        v.ihit = ihit; v.dhit = dhit; v.drd = drd; v.dwr = dwr;
        v.mh = mh; v.mr = mr; v.edr = edr;
        v.ews = ews; v.rs = rs; v.rt = rt; v.urt = urt;
        v.exp_out = exp_out;
        vecs.push_back(v);
    endtask

    task automatic drive1(input vec_t v);
        if1.ihit = v.ihit;  if1.dhit = v.dhit;  if1.m_dREN = v.drd; if1.m_dWEN = v.dwr;
        if1.m_halt = v.mh;  if1.m_redirect = v.mr; if1.e_dREN = v.edr;
        if1.e_regWSEL = v.ews; if1.d_rs = v.rs; if1.d_rt = v.rt; if1.d_uses_rt = v.urt;
    endtask

    function automatic logic [10:0] out1();
        return {if1.pc_en, if1.iREN, if1.fd_state, if1.de_state,
                if1.em_state, if1.mw_state, if1.halt};
    endfunction

    task automatic idle2();
        if2.ihit = 1'b0; if2.dhit = 1'b0; if2.m_dREN = 1'b0; if2.m_dWEN = 1'b0;
        if2.m_halt = 1'b0; if2.m_redirect = 1'b0; if2.e_dREN = 1'b0;
        if2.e_regWSEL = 5'd0; if2.d_rs = 5'd0; if2.d_rt = 5'd0; if2.d_uses_rt = 1'b0;
    endtask

    initial begin
        vec_t zero_v;
        n_cmp = 0;
        n_bad = 0;
        nrst  = 1'b0;
        nrst2 = 1'b0;
        zero_v = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 11'd0};
        drive1(zero_v);
        idle2();

        // ihit every cycle, no hazards: all NORMAL, PC advances (v0..v9)
        for (int k = 0; k < 10; k++)
            add(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,{1'b1,1'b1,N,N,N,N,1'b0});
        // dcache miss for 3 cycles, fetch lands on the first (v10..v12)
        add(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,{1'b0,1'b1,S,S,S,S,1'b0});
        add(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,{1'b0,1'b0,S,S,S,S,1'b0});
        add(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,{1'b0,1'b0,S,S,S,S,1'b0});
        // dhit arrives: proceeds on the saved fetch without refetch (v13)
        add(1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,{1'b1,1'b0,N,N,N,N,1'b0});
        // load-use on rs (v14), then clear (v15), then r0 destination is no hazard (v16)
        add(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,5'd8,5'd8,5'd0,1'b0,{1'b0,1'b1,S,F,N,N,1'b0});
        add(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5'd8,5'd8,5'd0,1'b0,{1'b1,1'b1,N,N,N,N,1'b0});
        add(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,5'd0,5'd0,5'd0,1'b0,{1'b1,1'b1,N,N,N,N,1'b0});
        // load-use on rt when used (v17), not when unused (v18)
        add(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,5'd9,5'd3,5'd9,1'b1,{1'b0,1'b1,S,F,N,N,1'b0});
        add(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,5'd9,5'd3,5'd9,1'b0,{1'b1,1'b1,N,N,N,N,1'b0});
        // redirect outranks load-use (v19)
        add(1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,5'd8,5'd8,5'd0,1'b0,{1'b1,1'b1,F,F,F,N,1'b0});
        // fetch not returned (v20)
        add(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,{1'b0,1'b1,F,N,N,N,1'b0});
        // redirect deferred behind store miss (v21), acted on at dhit (v22)
        add(1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,5'd0,5'd0,5'd0,1'b0,{1'b0,1'b1,S,S,S,S,1'b0});
        add(1'b1,1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,5'd0,5'd0,5'd0,1'b0,{1'b1,1'b1,F,F,F,N,1'b0});
        // halt outranks redirect (v23), DRAIN (v24), HALTED (v25, v26)
        add(1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,5'd0,5'd0,5'd0,1'b0,{1'b0,1'b1,S,S,F,N,1'b0});
        add(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,{1'b0,1'b0,S,S,F,N,1'b0});
        add(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,{1'b0,1'b0,S,S,S,S,1'b1});
        add(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,{1'b0,1'b0,S,S,S,S,1'b1});

        // Reset state, outputs while reset held
        @(posedge clk); #1;
        chk("reset_outputs", 32'(out1()), 32'({1'b0,1'b1,S,S,S,S,1'b0}));
        chk("reset_stall_cnt", if1.stall_cnt, 32'd0);

        // Table-driven run; reset released together with the first vector
        for (int i = 0; i < vecs.size(); i++) begin
            drive1(vecs[i]);
            nrst = 1'b1;
            @(negedge clk);
            chk($sformatf("vec%0d_outputs", i), 32'(out1()), 32'(vecs[i].exp_out));
            @(posedge clk); #1;
            if (i == 9)  chk("stall_cnt_after_clean_run", if1.stall_cnt, 32'd0);
            if (i == 13) chk("stall_cnt_after_miss", if1.stall_cnt, 32'd3);
            if (i == 22) begin
                chk("stall_cnt_after_hazards", if1.stall_cnt, 32'd7);
                chk("flush_cnt_after_redirects", if1.flush_cnt, 32'd2);
            end
            if (i == 26) begin
                chk("stall_cnt_frozen_halted", if1.stall_cnt, 32'd8);
                chk("flush_cnt_halt_over_redirect", if1.flush_cnt, 32'd2);
            end
        end

        // Async reset while HALTED, mid-cycle
        #2 nrst = 1'b0;
        #1;
        chk("async_rst_halt", 32'(if1.halt), 32'd0);
        chk("async_rst_iren", 32'(if1.iREN), 32'd1);
        chk("async_rst_stall_cnt", if1.stall_cnt, 32'd0);
        chk("async_rst_flush_cnt", if1.flush_cnt, 32'd0);

        // Async reset mid-dbusy clears the saved-fetch flag
        zero_v.ihit = 1'b1; zero_v.drd = 1'b1;
        drive1(zero_v);
        @(negedge clk) nrst = 1'b1;
        @(posedge clk); #1;
        chk("dbusy_iren_after_fetch", 32'(if1.iREN), 32'd0);
        chk("dbusy_stall_cnt", if1.stall_cnt, 32'd1);
        #2 nrst = 1'b0;
        #1;
        chk("rst_mid_dbusy_iren", 32'(if1.iREN), 32'd1);
        chk("rst_mid_dbusy_stall_cnt", if1.stall_cnt, 32'd0);

        // Narrow counters: stall_cnt saturates at 3'b111
        idle2();
        nrst2 = 1'b1;
        repeat (6) @(posedge clk);
        #1 chk("sat_stall_cnt_counting", 32'(if2.stall_cnt), 32'd6);
        repeat (3) @(posedge clk);
        #1 chk("sat_stall_cnt_held", 32'(if2.stall_cnt), 32'd7);

        // flush_cnt saturates after 9 redirects
        if2.ihit = 1'b1; if2.m_redirect = 1'b1;
        repeat (9) @(posedge clk);
        #1 chk("sat_flush_cnt_held", 32'(if2.flush_cnt), 32'd7);
        chk("sat_stall_cnt_unchanged", 32'(if2.stall_cnt), 32'd7);

        // Halt with a 3-cycle drain
        if2.m_redirect = 1'b0; if2.m_halt = 1'b1;
        @(negedge clk);
        chk("drain3_entry_em", 32'(if2.em_state), 32'(F));
        @(posedge clk); #1;
        if2.m_halt = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("drain3_cycle%0d_halt_em", k), 32'({if2.halt, if2.em_state}), 32'({1'b0, F}));
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("drain3_halted", 32'({if2.halt, if2.iREN, if2.em_state}), 32'({1'b1, 1'b0, S}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
